// File: rtl/instruction_fetch_unit.sv
// instruction_fetch_unit: SPARC fetch stage with PC/nPC delayed branch, MFC handshake and sticky faults
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          MFC_TIMEOUT  = 16,
  parameter logic [5:0]  LOAD_WORD_OP = 6'b000000
) (
  input  logic        Clk,
  input  logic        RESET,
  input  logic        MFC,
  input  logic [31:0] mem_data,
  input  logic        exec_done,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic [31:0] mem_addr,
  output logic        mem_enable,
  output logic [5:0]  mem_opcode,
  output logic [31:0] IR_Out,
  output logic        ir_valid,
  output logic [31:0] PC_out,
  output logic [31:0] NPC_out,
  output logic [1:0]  fetch_fault
);
  localparam int CW = $clog2(MFC_TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MFC_TIMEOUT - 1);
  typedef enum logic [2:0] {IDLE, REQ, WAIT_MFC, LOAD_IR, ISSUE, UPDATE, FAULT} state_t;
  state_t state, state_n;
  logic [CW-1:0] cnt;
  logic [31:0] pc, npc, br_target;
  logic br_taken;
  logic misaligned, timeout;
  assign misaligned = pc[1:0] != 2'b00;
  assign timeout = cnt == CNT_LAST;
  assign mem_opcode = LOAD_WORD_OP;
  assign PC_out = pc;
  assign NPC_out = npc;
  always_ff @(posedge Clk) state <= RESET ? IDLE : state_n;
  always_comb begin
    state_n = state;
    case (state)
      IDLE:     state_n = REQ;
      REQ:      state_n = misaligned ? FAULT : WAIT_MFC;
      WAIT_MFC: state_n = MFC ? LOAD_IR : (timeout ? FAULT : WAIT_MFC);
      LOAD_IR:  state_n = ISSUE;
      ISSUE:    state_n = exec_done ? UPDATE : ISSUE;
      UPDATE:   state_n = REQ;
      default:  state_n = FAULT;
    endcase
  end
  // branch decision is latched with exec_done and applied one cycle later in UPDATE
  always_ff @(posedge Clk) begin
    if (RESET) begin
      pc <= RESET_PC;
      npc <= RESET_PC + 32'd4;
      IR_Out <= '0;
      ir_valid <= 1'b0;
      mem_enable <= 1'b0;
      mem_addr <= '0;
      fetch_fault <= 2'b00;
      cnt <= '0;
      br_taken <= 1'b0;
      br_target <= '0;
    end else begin
      case (state)
        REQ: begin
          if (misaligned) fetch_fault <= 2'b01;
          else begin
            mem_addr <= pc;
            mem_enable <= 1'b1;
            cnt <= '0;
          end
        end
        WAIT_MFC: begin
          if (MFC) begin
            IR_Out <= mem_data;
            mem_enable <= 1'b0;
          end else if (timeout) begin
            fetch_fault <= 2'b10;
            mem_enable <= 1'b0;
          end else cnt <= cnt + 1'b1;
        end
        LOAD_IR: ir_valid <= 1'b1;
        ISSUE: begin
          if (exec_done) begin
            ir_valid <= 1'b0;
            br_taken <= branch_taken;
            br_target <= branch_target;
          end
        end
        UPDATE: begin
          pc <= npc;
          npc <= br_taken ? br_target : npc + 32'd4;
        end
        default: ;
      endcase
    end
  end
endmodule
